// File: rtl/dmux16_stream_pkg.sv
// Shared definitions for the 16-bit stream demultiplexer: word width,
// counter width and the destination-select encoding.
package dmux16_stream_pkg;

    localparam int DATA_W  = 16;
    localparam int COUNT_W = 16;

    // Destination encoding carried on in_sel.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/dmux16_fifo.sv
// Synchronous FIFO with registered occupancy. Pointers carry one extra MSB
// so that full (occupancy == DEPTH) and empty (occupancy == 0) are distinct.
// Push is refused while full even if a pop happens in the same cycle; pop
// is ignored while empty. The head word is always driven, also when empty.
module dmux16_fifo
    import dmux16_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               do_push;
    logic               do_pop;

    // Pointer difference wraps naturally thanks to the extra MSB.
    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == FULL_LEVEL);
    assign empty     = (occupancy == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Advance write/read pointers on accepted push/pop.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Write the pushed word into its slot; storage clears on reset.
    // NOTE: the storage array is deliberately reset because the head word is
    // visible even while empty and must read 0x0000 after reset; this forces
    // flops instead of RAM, which is fine for a few entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dmux16_stream.sv
// Registered 1-to-2 demultiplexer for 16-bit valid/ready word streams.
// Each word is steered by in_sel into the FIFO of port A or port B; each
// port back-pressures independently, and a wrapping per-port count of
// accepted words is kept for debug.
module dmux16_stream
    import dmux16_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   a_data,
    output logic                a_valid,
    input  logic                a_ready,
    output logic [DATA_W-1:0]   b_data,
    output logic                b_valid,
    input  logic                b_ready,
    output logic [COUNT_W-1:0]  a_count,
    output logic [COUNT_W-1:0]  b_count
);

    localparam int unsigned      AW        = $clog2(DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    logic           full_a;
    logic           full_b;
    logic           empty_a;
    logic           empty_b;
    logic [AW:0]    occ_a;
    logic [AW:0]    occ_b;
    logic           push_a;
    logic           push_b;
    logic           sel_b;
    logic           unused_occ;

    assign sel_b = (port_e'(in_sel) == PORT_B);

    // Readiness depends only on registered occupancy of the selected port,
    // never on the downstream ready inputs.
    assign in_ready = sel_b ? ~full_b : ~full_a;

    assign push_a = in_valid & in_ready & ~sel_b;
    assign push_b = in_valid & in_ready &  sel_b;

    assign a_valid = ~empty_a;
    assign b_valid = ~empty_b;

    // Occupancy is exported by the FIFO for debug; the top only needs flags.
    assign unused_occ = ^{occ_a, occ_b};

    dmux16_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (a_ready),
        .head_data (a_data),
        .full      (full_a),
        .empty     (empty_a),
        .occupancy (occ_a)
    );

    dmux16_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (b_ready),
        .head_data (b_data),
        .full      (full_b),
        .empty     (empty_b),
        .occupancy (occ_b)
    );

    // Per-port accepted-word counters; wrap silently modulo 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (push_a) a_count <= a_count + COUNT_ONE;
            if (push_b) b_count <= b_count + COUNT_ONE;
        end
    end

endmodule

// File: tb/tb_dmux16_stream.sv
// Self-checking bench for dmux16_stream: a constant vector table for
// routing and back-pressure, hand sequences for full-with-pop, counter wrap
// and asynchronous reset, and randomized traffic against a queue model.
module tb_dmux16_stream;
    import dmux16_stream_pkg::*;

    localparam int DEPTH = 2;

    logic                clk;
    logic                rst_n;
    logic [DATA_W-1:0]   in_data;
    logic                in_sel;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   a_data;
    logic                a_valid;
    logic                a_ready;
    logic [DATA_W-1:0]   b_data;
    logic                b_valid;
    logic                b_ready;
    logic [COUNT_W-1:0]  a_count;
    logic [COUNT_W-1:0]  b_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one queue per port plus total accepted words.
    logic [15:0]  qa[$];
    logic [15:0]  qb[$];
    int unsigned  a_total;
    int unsigned  b_total;

    dmux16_stream #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream protocol monitor: a stalled word must not change.
    logic        stall_q;
    logic        sel_q;
    logic [15:0] data_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q && in_valid && (in_sel !== sel_q || in_data !== data_q))
                $error("protocol violation: stalled word changed");
            stall_q <= in_valid && !in_ready;
            sel_q   <= in_sel;
            data_q  <= in_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        a_total = 0;
        b_total = 0;
    endtask

    task automatic check_model_outputs();
        check("a_valid", a_valid, qa.size() != 0);
        check("b_valid", b_valid, qb.size() != 0);
        if (qa.size() != 0) check("a_data", a_data, qa[0]);
        if (qb.size() != 0) check("b_data", b_data, qb[0]);
        check("a_count", a_count, a_total % 65536);
        check("b_count", b_count, b_total % 65536);
    endtask

    // One clock of model-checked traffic; acc reports whether the word went in.
    task automatic step(input logic v, input logic s, input logic [15:0] d,
                        input logic ar, input logic br, input bit chk, output bit acc);
        bit exp_rdy;
        bit pa;
        bit pb;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
        exp_rdy = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        if (chk) check("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        pa  = ar && (qa.size() != 0);
        pb  = br && (qb.size() != 0);
        @(posedge clk);
        #1;
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (acc) begin
            if (s) begin
                qb.push_back(d);
                b_total++;
            end else begin
                qa.push_back(d);
                a_total++;
            end
        end
        if (chk) check_model_outputs();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Table vectors: inputs and the expected state after the edge.
    typedef struct {
        logic        v;
        logic        s;
        logic [15:0] d;
        logic        ar;
        logic        br;
        logic        rdy;
        logic        av;
        logic [15:0] ad;
        logic        bv;
        logic [15:0] bd;
        logic [15:0] ac;
        logic [15:0] bc;
    } vec_t;

    task automatic apply_vec(input vec_t t, input int idx);
        in_valid = t.v;
        in_sel   = t.s;
        in_data  = t.d;
        a_ready  = t.ar;
        b_ready  = t.br;
        #1;
        check($sformatf("vec%0d in_ready", idx), in_ready, t.rdy);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d a_valid", idx), a_valid, t.av);
        check($sformatf("vec%0d a_data", idx),  a_data,  t.ad);
        check($sformatf("vec%0d b_valid", idx), b_valid, t.bv);
        check($sformatf("vec%0d b_data", idx),  b_data,  t.bd);
        check($sformatf("vec%0d a_count", idx), a_count, t.ac);
        check($sformatf("vec%0d b_count", idx), b_count, t.bc);
    endtask

    initial begin
        vec_t        tbl[11];
        bit          acc;
        logic        pv;
        logic        ps;
        logic [15:0] pd;

        //            v  s  data     ar br rdy av ad       bv bd       ac bc
        tbl[0]  = '{1, 0, 16'h1234, 1, 1, 1, 1, 16'h1234, 0, 16'h0000, 1, 0};
        tbl[1]  = '{1, 1, 16'hBEEF, 1, 1, 1, 0, 16'h0000, 1, 16'hBEEF, 1, 1};
        tbl[2]  = '{0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 1};
        tbl[3]  = '{1, 1, 16'h0001, 1, 0, 1, 0, 16'h0000, 1, 16'h0001, 1, 2};
        tbl[4]  = '{1, 1, 16'h0002, 1, 0, 1, 0, 16'h0000, 1, 16'h0001, 1, 3};
        tbl[5]  = '{0, 1, 16'h0003, 0, 0, 0, 0, 16'h0000, 1, 16'h0001, 1, 3};
        tbl[6]  = '{1, 0, 16'h00AA, 0, 0, 1, 1, 16'h00AA, 1, 16'h0001, 2, 3};
        tbl[7]  = '{1, 1, 16'h0003, 0, 0, 0, 1, 16'h00AA, 1, 16'h0001, 2, 3};
        tbl[8]  = '{1, 1, 16'h0003, 0, 1, 0, 1, 16'h00AA, 1, 16'h0002, 2, 3};
        tbl[9]  = '{1, 1, 16'h0003, 0, 1, 1, 1, 16'h00AA, 1, 16'h0003, 2, 4};
        tbl[10] = '{0, 1, 16'h0000, 1, 1, 1, 0, 16'h1234, 0, 16'h0002, 2, 4};

        // Reset then idle.
        do_reset();
        #1;
        check("reset in_ready", in_ready, 1'b1);
        check("reset a_valid",  a_valid,  1'b0);
        check("reset b_valid",  b_valid,  1'b0);
        check("reset a_data",   a_data,   16'h0000);
        check("reset b_data",   b_data,   16'h0000);
        check("reset a_count",  a_count,  16'h0000);
        check("reset b_count",  b_count,  16'h0000);
        @(posedge clk);
        #1;

        // Routing, latency and back-pressure from the vector table.
        foreach (tbl[i]) apply_vec(tbl[i], i);

        // Full A with a pop and a pending push in the same cycle.
        do_reset();
        step(1, 0, 16'h0010, 0, 0, 1, acc);
        step(1, 0, 16'h0011, 0, 0, 1, acc);
        step(1, 0, 16'h0012, 1, 0, 1, acc);
        check("fullpop refused a_count", a_count, 16'h0002);
        check("fullpop head", a_data, 16'h0011);
        step(1, 0, 16'h0012, 1, 0, 1, acc);
        check("fullpop accepted a_count", a_count, 16'h0003);
        step(0, 0, 16'h0000, 1, 0, 1, acc);
        step(0, 0, 16'h0000, 1, 0, 1, acc);

        // Randomized traffic against the queue model.
        do_reset();
        pv = 1'b0;
        ps = 1'b0;
        pd = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 1'($urandom_range(0, 1));
                pd = 16'($urandom);
            end
            step(pv, ps, pd, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 1'b1, acc);
            if (acc) pv = 1'b0;
        end
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0000, 1, 1, 1, acc);

        // Counter wrap: 65537 accepted pushes to A.
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            step(1, 0, 16'(i), 1, 1, 1'b0, acc);
        end
        check("wrap a_count", a_count, 16'h0001);
        check("wrap b_count", b_count, 16'h0000);
        step(0, 0, 16'h0000, 1, 1, 1, acc);

        // Asynchronous reset with both FIFOs full.
        do_reset();
        step(1, 0, 16'hA001, 0, 0, 1, acc);
        step(1, 0, 16'hA002, 0, 0, 1, acc);
        step(1, 1, 16'hB001, 0, 0, 1, acc);
        step(1, 1, 16'hB002, 0, 0, 1, acc);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async a_valid",  a_valid,  1'b0);
        check("async b_valid",  b_valid,  1'b0);
        check("async a_count",  a_count,  16'h0000);
        check("async b_count",  b_count,  16'h0000);
        check("async a_data",   a_data,   16'h0000);
        check("async b_data",   b_data,   16'h0000);
        check("async in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 16'hDEAD;
        a_ready  = 1'b1;
        @(posedge clk);
        #1;
        check("in-reset push a_valid", a_valid, 1'b0);
        check("in-reset push a_count", a_count, 16'h0000);
        #2;
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 16'h5A5A, 0, 0, 1, acc);
        check("post-reset a_data", a_data, 16'h5A5A);
        step(0, 0, 16'h0000, 1, 1, 1, acc);
        step(0, 1, 16'h0000, 1, 1, 1, acc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
